// File: rtl/xbar_out_allocator.sv
// Output-port allocator: round-robin arbitration over five inputs, wormhole
// ownership of the output until a tail flit moves, and downstream credit tracking.
module xbar_out_allocator #(
    parameter int CREDIT_COUNT = 4,
    parameter int CNT_WIDTH    = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [4:0]           req,
    input  logic [4:0]           tail,
    input  logic                 credit_in,
    output logic [4:0]           sel,
    output logic [4:0]           grant,
    output logic                 valid_out,
    output logic [CNT_WIDTH-1:0] credit_cnt
);

    localparam logic [CNT_WIDTH-1:0] CMAX = CNT_WIDTH'(CREDIT_COUNT);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    state_t               r_state;
    logic [4:0]           r_sel;
    logic [2:0]           r_last;
    logic [CNT_WIDTH-1:0] r_credit;

    logic                 w_xfer;
    logic                 w_tail_xfer;
    logic                 w_win_found;
    logic [2:0]           w_win_idx;
    logic [3:0]           w_scan;

    // r_sel is zero outside LOCKED, so it alone qualifies a transfer; reset masks strobes.
    assign w_xfer      = reset && (|(r_sel & req)) && (r_credit != '0);
    assign w_tail_xfer = w_xfer && (|(r_sel & tail));

    assign sel        = r_sel;
    assign grant      = w_xfer ? r_sel : 5'b00000;
    assign valid_out  = w_xfer;
    assign credit_cnt = r_credit;

    // Scan upward from the input after the previous winner, wrapping at 5.
    always_comb begin
        w_win_found = 1'b0;
        w_win_idx   = 3'd0;
        w_scan      = 4'd0;
        for (int i = 1; i <= 5; i++) begin
            w_scan = {1'b0, r_last} + 4'(i);
            if (w_scan >= 4'd5) begin
                w_scan = w_scan - 4'd5;
            end
            if (!w_win_found && req[w_scan[2:0]]) begin
                w_win_found = 1'b1;
                w_win_idx   = w_scan[2:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_sel    <= 5'b00000;
            r_last   <= 3'd4;
            r_credit <= CMAX;
        end else begin
            // A returned credit and a sent flit cancel; an excess return saturates.
            if (credit_in && !w_xfer) begin
                if (r_credit != CMAX) begin
                    r_credit <= r_credit + CNT_WIDTH'(1);
                end
            end else if (!credit_in && w_xfer) begin
                r_credit <= r_credit - CNT_WIDTH'(1);
            end

            case (r_state)
                S_IDLE: begin
                    if (w_win_found) begin
                        r_state <= S_LOCKED;
                        r_sel   <= 5'b00001 << w_win_idx;
                        r_last  <= w_win_idx;
                    end
                end
                S_LOCKED: begin
                    if (w_tail_xfer) begin
                        r_state <= S_IDLE;
                        r_sel   <= 5'b00000;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_sel   <= 5'b00000;
                end
            endcase
        end
    end

endmodule
